// File: rtl/fft_pkg.sv
// Widths shared by every FFT stage: sample, product, partial-sum and butterfly-sum widths.
package fft_pkg;

    localparam int unsigned FFT_DATA_WIDTH = 16;
    localparam int unsigned FFT_FRAC_BITS  = 8;
    localparam int unsigned FFT_PROD_WIDTH = 2 * FFT_DATA_WIDTH;
    localparam int unsigned FFT_PSUM_WIDTH = FFT_PROD_WIDTH + 1;
    localparam int unsigned FFT_SUM_WIDTH  = FFT_PROD_WIDTH + 2;

    function automatic int unsigned prod_width(input int unsigned dw);
        return 2 * dw;
    endfunction

    function automatic int unsigned sum_width(input int unsigned dw);
        return 2 * dw + 2;
    endfunction

endpackage

// File: rtl/butterfly_r2_if.sv
// Operand, result and handshake bundle of the radix-2 butterfly.
interface butterfly_r2_if
    import fft_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = FFT_DATA_WIDTH
);

    logic signed [2*DATA_WIDTH-1:0] A_re;
    logic signed [2*DATA_WIDTH-1:0] A_im;
    logic signed [DATA_WIDTH-1:0]   B_re;
    logic signed [DATA_WIDTH-1:0]   B_im;
    logic signed [DATA_WIDTH-1:0]   W_re;
    logic signed [DATA_WIDTH-1:0]   W_im;
    logic                           in_valid;
    logic                           in_ready;
    logic                           out_valid;
    logic                           out_ready;
    logic signed [DATA_WIDTH-1:0]   Y0_re;
    logic signed [DATA_WIDTH-1:0]   Y0_im;
    logic signed [DATA_WIDTH-1:0]   Y1_re;
    logic signed [DATA_WIDTH-1:0]   Y1_im;
    logic                           clr_ovf;
    logic                           OVF;

    modport master (
        output A_re, A_im, B_re, B_im, W_re, W_im, in_valid, out_ready, clr_ovf,
        input  in_ready, out_valid, Y0_re, Y0_im, Y1_re, Y1_im, OVF
    );

    modport slave (
        input  A_re, A_im, B_re, B_im, W_re, W_im, in_valid, out_ready, clr_ovf,
        output in_ready, out_valid, Y0_re, Y0_im, Y1_re, Y1_im, OVF
    );

endinterface

// File: rtl/sat_round.sv
// Round half-up, arithmetic shift right by FRAC_BITS and saturate one butterfly sum.
module sat_round
    import fft_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = FFT_DATA_WIDTH,
    parameter int unsigned FRAC_BITS  = FFT_FRAC_BITS
) (
    input  logic signed [sum_width(DATA_WIDTH)-1:0] x,
    output logic signed [DATA_WIDTH-1:0]            y,
    output logic                                    sat
);

    localparam int unsigned IW = sum_width(DATA_WIDTH);
    // One extra bit so adding the rounding constant can never wrap.
    localparam int unsigned EW = IW + 1;

    localparam logic signed [EW-1:0] HALF = EW'(1) << (FRAC_BITS - 1);
    localparam logic signed [EW-1:0] MAXV = {{(EW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [EW-1:0] MINV = {{(EW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    logic signed [EW-1:0] rounded;
    logic signed [EW-1:0] shifted;

    always_comb begin
        rounded = EW'(x) + HALF;
        shifted = rounded >>> FRAC_BITS;
        y       = shifted[DATA_WIDTH-1:0];
        sat     = 1'b0;
        if (shifted > MAXV) begin
            y   = MAXV[DATA_WIDTH-1:0];
            sat = 1'b1;
        end else if (shifted < MINV) begin
            y   = MINV[DATA_WIDTH-1:0];
            sat = 1'b1;
        end
    end

endmodule

// File: rtl/butterfly_r2.sv
// Three-stage pipelined radix-2 DIT butterfly: Y0 = A + W*B, Y1 = A - W*B, sticky saturation flag.
module butterfly_r2
    import fft_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = FFT_DATA_WIDTH,
    parameter int unsigned FRAC_BITS  = FFT_FRAC_BITS
) (
    input  logic          CLK,
    input  logic          RST_n,
    butterfly_r2_if.slave bus
);

    localparam int unsigned PW = prod_width(DATA_WIDTH);
    localparam int unsigned QW = PW + 1;
    localparam int unsigned SW = sum_width(DATA_WIDTH);

    // Single global enable: the whole pipe moves together or not at all.
    logic en;
    logic out_valid_q;
    assign en           = bus.out_ready | ~out_valid_q;
    assign bus.in_ready = en;

    // S1: products
    logic                 v1_q;
    logic signed [PW-1:0] a1_re_q, a1_im_q, rr_q, ii_q, ri_q, ir_q;

    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            v1_q <= 1'b0;
        end else if (en) begin
            v1_q <= bus.in_valid;
        end
    end

    always_ff @(posedge CLK) begin
        if (en) begin
            a1_re_q <= bus.A_re;
            a1_im_q <= bus.A_im;
            rr_q    <= PW'(bus.W_re) * PW'(bus.B_re);
            ii_q    <= PW'(bus.W_im) * PW'(bus.B_im);
            ri_q    <= PW'(bus.W_re) * PW'(bus.B_im);
            ir_q    <= PW'(bus.W_im) * PW'(bus.B_re);
        end
    end

    // S2: complex product W*B
    logic                 v2_q;
    logic signed [PW-1:0] a2_re_q, a2_im_q;
    logic signed [QW-1:0] p_q, q_q;

    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            v2_q <= 1'b0;
        end else if (en) begin
            v2_q <= v1_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (en) begin
            a2_re_q <= a1_re_q;
            a2_im_q <= a1_im_q;
            p_q     <= QW'(rr_q) - QW'(ii_q);
            q_q     <= QW'(ri_q) + QW'(ir_q);
        end
    end

    // S3: sums, rounding, saturation
    logic signed [SW-1:0]         s0_re, s0_im, s1_re, s1_im;
    logic signed [DATA_WIDTH-1:0] y0_re_d, y0_im_d, y1_re_d, y1_im_d;
    logic [3:0]                   sat;

    assign s0_re = SW'(a2_re_q) + SW'(p_q);
    assign s0_im = SW'(a2_im_q) + SW'(q_q);
    assign s1_re = SW'(a2_re_q) - SW'(p_q);
    assign s1_im = SW'(a2_im_q) - SW'(q_q);

    sat_round #(.DATA_WIDTH(DATA_WIDTH), .FRAC_BITS(FRAC_BITS)) u_sr_y0_re (
        .x(s0_re), .y(y0_re_d), .sat(sat[0])
    );
    sat_round #(.DATA_WIDTH(DATA_WIDTH), .FRAC_BITS(FRAC_BITS)) u_sr_y0_im (
        .x(s0_im), .y(y0_im_d), .sat(sat[1])
    );
    sat_round #(.DATA_WIDTH(DATA_WIDTH), .FRAC_BITS(FRAC_BITS)) u_sr_y1_re (
        .x(s1_re), .y(y1_re_d), .sat(sat[2])
    );
    sat_round #(.DATA_WIDTH(DATA_WIDTH), .FRAC_BITS(FRAC_BITS)) u_sr_y1_im (
        .x(s1_im), .y(y1_im_d), .sat(sat[3])
    );

    logic signed [DATA_WIDTH-1:0] y0_re_q, y0_im_q, y1_re_q, y1_im_q;
    logic                         ovf_q;
    logic                         ovf_set;

    // Saturation from a bubble's stale data must never reach the flag.
    assign ovf_set = en & v2_q & (|sat);

    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            out_valid_q <= 1'b0;
            y0_re_q     <= '0;
            y0_im_q     <= '0;
            y1_re_q     <= '0;
            y1_im_q     <= '0;
        end else if (en) begin
            out_valid_q <= v2_q;
            y0_re_q     <= y0_re_d;
            y0_im_q     <= y0_im_d;
            y1_re_q     <= y1_re_d;
            y1_im_q     <= y1_im_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            ovf_q <= 1'b0;
        end else if (ovf_set) begin
            ovf_q <= 1'b1;
        end else if (bus.clr_ovf) begin
            ovf_q <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.Y0_re     = y0_re_q;
    assign bus.Y0_im     = y0_im_q;
    assign bus.Y1_re     = y1_re_q;
    assign bus.Y1_im     = y1_im_q;
    assign bus.OVF       = ovf_q;

endmodule

// File: tb/tb_butterfly_r2.sv
// Directed, table-driven bench for butterfly_r2 at DATA_WIDTH=16, FRAC_BITS=8.
module tb_butterfly_r2;
    import fft_pkg::*;

    localparam int DW = 16;
    localparam int AW = 2 * DW;
    localparam int FB = 8;
    localparam int NV = 8;

    typedef struct {
        int    a_re, a_im, b_re, b_im, w_re, w_im;
        int    y0_re, y0_im, y1_re, y1_im;
        bit    ovf;
        string name;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    butterfly_r2_if #(.DATA_WIDTH(DW)) bus ();

    butterfly_r2 #(.DATA_WIDTH(DW), .FRAC_BITS(FB)) dut (
        .CLK  (clk),
        .RST_n(rst_n),
        .bus  (bus)
    );

    int   tests_run    = 0;
    int   tests_failed = 0;
    vec_t vecs[NV];
    int   got[$];

    task automatic check(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.A_re = AW'(v.a_re);
        bus.A_im = AW'(v.a_im);
        bus.B_re = DW'(v.b_re);
        bus.B_im = DW'(v.b_im);
        bus.W_re = DW'(v.w_re);
        bus.W_im = DW'(v.w_im);
    endtask

    task automatic drive_idle();
        bus.A_re      = '0;
        bus.A_im      = '0;
        bus.B_re      = '0;
        bus.B_im      = '0;
        bus.W_re      = '0;
        bus.W_im      = '0;
        bus.in_valid  = 1'b0;
        bus.clr_ovf   = 1'b0;
        bus.out_ready = 1'b1;
    endtask

    // One transfer, wait for the result with a bounded loop, compare everything.
    task automatic run_vec(input vec_t v, input bit do_clr, input bit exp_ovf);
        int lat;
        @(negedge clk);
        drive(v);
        bus.in_valid = 1'b1;
        bus.clr_ovf  = do_clr;
        check({v.name, " in_ready"}, int'(bus.in_ready), 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.clr_ovf  = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check({v.name, " latency"}, lat, 3);
        check({v.name, " y0_re"}, int'(bus.Y0_re), v.y0_re);
        check({v.name, " y0_im"}, int'(bus.Y0_im), v.y0_im);
        check({v.name, " y1_re"}, int'(bus.Y1_re), v.y1_re);
        check({v.name, " y1_im"}, int'(bus.Y1_im), v.y1_im);
        check({v.name, " ovf"}, int'(bus.OVF), int'(exp_ovf));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int accepted;
        int idx;
        vec_t s;

        //           a_re      a_im  b_re    b_im    w_re    w_im    y0_re   y0_im   y1_re   y1_im
        vecs[0] = '{ 25600,    0,    50,     0,      256,    0,      150,    0,      50,     0,
                     1'b0, "identity"};
        vecs[1] = '{ 0,        0,    10,     20,     0,      -256,   20,     -10,    -20,    10,
                     1'b0, "rotation"};
        vecs[2] = '{ 0,        0,    3,      0,      128,    0,      2,      0,      -1,     0,
                     1'b0, "rounding"};
        vecs[3] = '{ 7680000,  0,    30000,  0,      256,    0,      32767,  0,      0,      0,
                     1'b1, "sat_pos"};
        vecs[4] = '{ -7680000, 0,    -30000, 0,      256,    0,      -32768, 0,      0,      0,
                     1'b1, "sat_neg"};
        vecs[5] = '{ 0,        0,    -32768, -32768, -32768, -32768, 0,      32767,  0,      -32768,
                     1'b1, "extreme"};
        vecs[6] = '{ -512,     768,  4,      -2,     64,     32,     -1,     3,      -3,     3,
                     1'b0, "mixed"};
        vecs[7] = '{ -128,     -384, 0,      0,      0,      0,      0,      -1,     0,      -1,
                     1'b0, "neg_tie"};

        drive_idle();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset out_valid", int'(bus.out_valid), 0);
        check("reset ovf", int'(bus.OVF), 0);
        check("reset y0_re", int'(bus.Y0_re), 0);
        check("reset y0_im", int'(bus.Y0_im), 0);
        check("reset y1_re", int'(bus.Y1_re), 0);
        check("reset y1_im", int'(bus.Y1_im), 0);
        rst_n = 1'b1;
        check("post-reset in_ready", int'(bus.in_ready), 1);

        for (int i = 0; i < NV; i++) begin
            run_vec(vecs[i], 1'b1, vecs[i].ovf);
        end

        // Sticky flag survives a clean result, then clr_ovf alone clears it.
        run_vec(vecs[3], 1'b1, 1'b1);
        run_vec(vecs[0], 1'b0, 1'b1);
        @(negedge clk);
        bus.clr_ovf = 1'b1;
        @(negedge clk);
        bus.clr_ovf = 1'b0;
        check("clr alone", int'(bus.OVF), 0);

        // clr_ovf coincident with a saturating S3 load: set wins.
        @(negedge clk);
        drive(vecs[3]);
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        bus.clr_ovf = 1'b1;
        @(negedge clk);
        bus.clr_ovf = 1'b0;
        check("coincident out_valid", int'(bus.out_valid), 1);
        check("coincident set wins", int'(bus.OVF), 1);
        bus.clr_ovf = 1'b1;
        @(negedge clk);
        bus.clr_ovf = 1'b0;
        check("clr after coincident", int'(bus.OVF), 0);

        // Stall: out_ready low, in_valid held for 6 cycles.
        bus.out_ready = 1'b0;
        accepted = 0;
        idx = 1;
        for (int c = 0; c < 6; c++) begin
            s = '{idx * 256, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0, "stall"};
            drive(s);
            bus.in_valid = 1'b1;
            if (bus.in_ready) begin
                accepted++;
                idx++;
            end
            @(negedge clk);
            if (c >= 3) begin
                check("stall hold out_valid", int'(bus.out_valid), 1);
                check("stall hold y0_re", int'(bus.Y0_re), 1);
            end
        end
        check("stall accepted", accepted, 3);
        check("stall in_ready", int'(bus.in_ready), 0);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        got.delete();
        for (int c = 0; c < 8; c++) begin
            if (bus.out_valid) got.push_back(int'(bus.Y0_re));
            @(negedge clk);
        end
        check("drain count", got.size(), 3);
        for (int i = 0; i < 3; i++) begin
            check("drain order", (i < got.size()) ? got[i] : -99999, i + 1);
        end

        // Reset with three saturating samples in flight.
        bus.clr_ovf = 1'b1;
        @(negedge clk);
        bus.clr_ovf = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(vecs[3]);
            bus.in_valid = 1'b1;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        check("pre-reset out_valid", int'(bus.out_valid), 1);
        check("pre-reset ovf", int'(bus.OVF), 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mid-reset out_valid", int'(bus.out_valid), 0);
        check("mid-reset ovf", int'(bus.OVF), 0);
        check("mid-reset in_ready", int'(bus.in_ready), 1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("no stale output", int'(bus.out_valid), 0);
            check("no stale ovf", int'(bus.OVF), 0);
        end
        run_vec(vecs[0], 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
